// File: rtl/dec_gain_sched_if.sv
// Bundle of everything exchanged between the gain-decode scheduler and its parent:
// the subframe handshake, per-client control and request buses, and the shared
// operator / scratch-memory drive.
interface dec_gain_sched_if #(parameter int NCLI = 3);
    // subframe handshake
    logic                 start;
    logic                 bfi;
    logic                 done;
    logic                 busy;
    logic                 timeout_err;
    logic [1:0]           grant;

    // per-client control
    logic [NCLI-1:0]      c_start;
    logic [NCLI-1:0]      c_done;

    // per-client requests, client k in slice k
    logic [16*NCLI-1:0]   c_add_a, c_add_b, c_sub_a, c_sub_b, c_L_shr_b;
    logic [32*NCLI-1:0]   c_L_add_a, c_L_add_b, c_L_shr_a, c_mem_out;
    logic [NCLI-1:0]      c_mem_we;
    logic [12*NCLI-1:0]   c_mem_raddr, c_mem_waddr;

    // shared operators and scratch memory
    logic [15:0]          add_a, add_b, sub_a, sub_b, L_shr_b;
    logic [31:0]          L_add_a, L_add_b, L_shr_a;
    logic                 scratch_mem_write_en;
    logic [11:0]          scratch_mem_read_addr, scratch_mem_write_addr;
    logic [31:0]          scratch_mem_out;

    // parent side: issues subframes, hosts the clients
    modport master (
        output start, bfi, c_done,
        output c_add_a, c_add_b, c_sub_a, c_sub_b, c_L_shr_b,
        output c_L_add_a, c_L_add_b, c_L_shr_a, c_mem_out,
        output c_mem_we, c_mem_raddr, c_mem_waddr,
        input  done, busy, timeout_err, grant, c_start,
        input  add_a, add_b, sub_a, sub_b, L_shr_b, L_add_a, L_add_b, L_shr_a,
        input  scratch_mem_write_en, scratch_mem_read_addr, scratch_mem_write_addr,
        input  scratch_mem_out
    );

    // scheduler side
    modport slave (
        input  start, bfi, c_done,
        input  c_add_a, c_add_b, c_sub_a, c_sub_b, c_L_shr_b,
        input  c_L_add_a, c_L_add_b, c_L_shr_a, c_mem_out,
        input  c_mem_we, c_mem_raddr, c_mem_waddr,
        output done, busy, timeout_err, grant, c_start,
        output add_a, add_b, sub_a, sub_b, L_shr_b, L_add_a, L_add_b, L_shr_a,
        output scratch_mem_write_en, scratch_mem_read_addr, scratch_mem_write_addr,
        output scratch_mem_out
    );
endinterface

// File: rtl/dec_gain_sched.sv
// Gain-decode sequencer and arbiter: launches gain decode (good frame) or
// conceal followed by update-on-erasure (bad frame), one client at a time, and
// routes the running client's operator and scratch-memory requests to the
// shared resources. A watchdog aborts a client that never reports done.
module dec_gain_sched #(
    parameter int TIMEOUT = 4095,
    parameter int NCLI    = 3
) (
    input  logic              clk,
    input  logic              reset,
    dec_gain_sched_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, FIN} state_t;

    localparam logic [1:0]  NO_GRANT = 2'(NCLI);
    localparam logic [15:0] LIMIT    = 16'(TIMEOUT);
    localparam logic [1:0]  CONCEAL  = 2'd1;
    localparam logic [1:0]  UPDATE   = 2'd2;

    state_t          state;
    logic [1:0]      cur;        // client being launched / run
    logic [15:0]     count;      // cycles spent in WAIT, saturating
    logic            done_q, busy_q, terr_q;
    logic [1:0]      grant_q;
    logic [NCLI-1:0] c_start_q;

    assign bus.done        = done_q;
    assign bus.busy        = busy_q;
    assign bus.timeout_err = terr_q;
    assign bus.grant       = grant_q;
    assign bus.c_start     = c_start_q;

    // Sequencer: walks the client list for one subframe, all outputs registered
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cur       <= 2'd0;
            count     <= 16'd0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            terr_q    <= 1'b0;
            grant_q   <= NO_GRANT;
            c_start_q <= '0;
        end else begin
            // NOTE: non-blocking everywhere here so every register sees pre-edge values.
            done_q    <= 1'b0;
            c_start_q <= '0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        cur    <= bus.bfi ? CONCEAL : 2'd0;
                        terr_q <= 1'b0;
                        busy_q <= 1'b1;
                        state  <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    grant_q   <= cur;
                    c_start_q <= NCLI'(1) << cur;
                    count     <= 16'd0;
                    state     <= WAIT;
                end
                WAIT: begin
                    // a done arriving with the timeout takes priority
                    if (bus.c_done[cur]) begin
                        if (cur == CONCEAL) begin
                            cur   <= UPDATE;
                            state <= LAUNCH;
                        end else begin
                            state <= FIN;
                        end
                    end else if (count >= LIMIT) begin
                        terr_q <= 1'b1;
                        state  <= FIN;
                    end else if (count != 16'hFFFF) begin
                        count <= count + 16'd1;
                    end
                end
                FIN: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    grant_q <= NO_GRANT;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Resource mux: only the granted client's requests reach the shared resources
    always_comb begin
        // NOTE: every output defaulted first so no path leaves a latch behind.
        bus.add_a                  = '0;
        bus.add_b                  = '0;
        bus.sub_a                  = '0;
        bus.sub_b                  = '0;
        bus.L_shr_b                = '0;
        bus.L_add_a                = '0;
        bus.L_add_b                = '0;
        bus.L_shr_a                = '0;
        bus.scratch_mem_write_en   = 1'b0;
        bus.scratch_mem_read_addr  = '0;
        bus.scratch_mem_write_addr = '0;
        bus.scratch_mem_out        = '0;
        for (int k = 0; k < NCLI; k++) begin
            if (grant_q == 2'(k)) begin
                bus.add_a                  = bus.c_add_a[16*k +: 16];
                bus.add_b                  = bus.c_add_b[16*k +: 16];
                bus.sub_a                  = bus.c_sub_a[16*k +: 16];
                bus.sub_b                  = bus.c_sub_b[16*k +: 16];
                bus.L_shr_b                = bus.c_L_shr_b[16*k +: 16];
                bus.L_add_a                = bus.c_L_add_a[32*k +: 32];
                bus.L_add_b                = bus.c_L_add_b[32*k +: 32];
                bus.L_shr_a                = bus.c_L_shr_a[32*k +: 32];
                bus.scratch_mem_write_en   = bus.c_mem_we[k];
                bus.scratch_mem_read_addr  = bus.c_mem_raddr[12*k +: 12];
                bus.scratch_mem_write_addr = bus.c_mem_waddr[12*k +: 12];
                bus.scratch_mem_out        = bus.c_mem_out[32*k +: 32];
            end
        end
    end
endmodule
